regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback.sv | 231 +++++++++++++++++++++++
 tb/tb_regfile_writeback.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-back stage feeding the single write port of the
// 64x32 register file. Result beats from the ALU and MAC producers are
// arbitrated round-robin, queued in order in a small FIFO and retired one per
// cycle through registered write outputs.
//
// Optional feature: define WB_HAZARD_EN to add read-address hazard outputs
// (rdAddrA/B/C -> hazardA/B/C) that flag reads of registers with a write
// still pending in the queue or on the write port.
module regfile_writeback #(
    parameter int NUM_ADDR_BITS = 6,
    parameter int REG_WIDTH     = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     aluValid,
    output logic                     aluReady,
    input  logic [NUM_ADDR_BITS-1:0] aluAddr,
    input  logic [REG_WIDTH-1:0]     aluData,
    input  logic                     macValid,
    output logic                     macReady,
    input  logic [NUM_ADDR_BITS-1:0] macAddr,
    input  logic [REG_WIDTH-1:0]     macData,
    input  logic                     wbHold,
`ifdef WB_HAZARD_EN
    input  logic [NUM_ADDR_BITS-1:0] rdAddrA,
    input  logic [NUM_ADDR_BITS-1:0] rdAddrB,
    input  logic [NUM_ADDR_BITS-1:0] rdAddrC,
    output logic                     hazardA,
    output logic                     hazardB,
    output logic                     hazardC,
`endif
    output logic                     writeEnable,
    output logic [NUM_ADDR_BITS-1:0] wrAddr,
    output logic [REG_WIDTH-1:0]     wrData,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                     idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Queue storage and bookkeeping
    logic [NUM_ADDR_BITS-1:0] addr_mem_q [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]     data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    // Round-robin state: 1 means the MAC received the most recent grant
    logic                     last_mac_q, last_mac_d;

    // Registered write-port outputs
    logic                     we_q, we_d;
    logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [REG_WIDTH-1:0]     wr_data_q, wr_data_d;

    // Per-cycle control
    logic                     full_s;
    logic                     empty_s;
    logic                     alu_grant_s;
    logic                     mac_grant_s;
    logic                     push_s;
    logic                     pop_s;
    logic [NUM_ADDR_BITS-1:0] push_addr_s;
    logic [REG_WIDTH-1:0]     push_data_s;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Arbitrate the two producers; a full queue refuses both, even while popping
    always_comb begin
        alu_grant_s = 1'b0;
        mac_grant_s = 1'b0;
        if (!full_s) begin
            if (aluValid && macValid) begin
                if (last_mac_q) begin
                    alu_grant_s = 1'b1;
                end else begin
                    mac_grant_s = 1'b1;
                end
            end else if (aluValid) begin
                alu_grant_s = 1'b1;
            end else if (macValid) begin
                mac_grant_s = 1'b1;
            end else begin
                alu_grant_s = 1'b0;
                mac_grant_s = 1'b0;
            end
        end else begin
            alu_grant_s = 1'b0;
            mac_grant_s = 1'b0;
        end
    end

    assign aluReady = alu_grant_s;
    assign macReady = mac_grant_s;
    assign push_s   = alu_grant_s | mac_grant_s;
    assign pop_s    = !empty_s && !wbHold;

    // Select the beat being enqueued this cycle
    always_comb begin
        push_addr_s = {NUM_ADDR_BITS{1'b0}};
        push_data_s = {REG_WIDTH{1'b0}};
        if (mac_grant_s) begin
            push_addr_s = macAddr;
            push_data_s = macData;
        end else begin
            push_addr_s = aluAddr;
            push_data_s = aluData;
        end
    end

    // Next-state for pointers, count, round-robin state and write port
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_mac_d = last_mac_q;
        we_d       = pop_s;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            wr_addr_d = addr_mem_q[rd_ptr_q];
            wr_data_d = data_mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (alu_grant_s) begin
            last_mac_d = 1'b0;
        end else if (mac_grant_s) begin
            last_mac_d = 1'b1;
        end else begin
            last_mac_d = last_mac_q;
        end
    end

    // Control and output registers; reset discards all queued beats
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            last_mac_q <= 1'b1;
            we_q       <= 1'b0;
            wr_addr_q  <= {NUM_ADDR_BITS{1'b0}};
            wr_data_q  <= {REG_WIDTH{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_mac_q <= last_mac_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Queue storage: write the granted beat at the tail
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem_q[i] <= {NUM_ADDR_BITS{1'b0}};
                data_mem_q[i] <= {REG_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            addr_mem_q[wr_ptr_q] <= push_addr_s;
            data_mem_q[wr_ptr_q] <= push_data_s;
        end else begin
            addr_mem_q[wr_ptr_q] <= addr_mem_q[wr_ptr_q];
            data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
        end
    end

    assign writeEnable = we_q;
    assign wrAddr      = wr_addr_q;
    assign wrData      = wr_data_q;
    assign fifoCount   = count_q;
    assign idle        = empty_s && !we_q;

`ifdef WB_HAZARD_EN
    logic [FIFO_DEPTH-1:0] entry_valid_s;

    // An entry is live when its distance from the head is below the count
    always_comb begin
        entry_valid_s = {FIFO_DEPTH{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [PTR_W-1:0] offset_s;
            offset_s         = PTR_W'(i) - rd_ptr_q;
            entry_valid_s[i] = ({1'b0, offset_s} < count_q);
        end
    end

    // Flag reads that target a register with a write still pending
    always_comb begin
        hazardA = we_q && (wr_addr_q == rdAddrA);
        hazardB = we_q && (wr_addr_q == rdAddrB);
        hazardC = we_q && (wr_addr_q == rdAddrC);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid_s[i]) begin
                hazardA = hazardA | (addr_mem_q[i] == rdAddrA);
                hazardB = hazardB | (addr_mem_q[i] == rdAddrB);
                hazardC = hazardC | (addr_mem_q[i] == rdAddrC);
            end else begin
                hazardA = hazardA;
                hazardB = hazardB;
                hazardC = hazardC;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback. A behavioural register file and
// write log capture every committed write for order and value checks.
module tb_regfile_writeback;

    logic        clk;
    logic        resetN;
    logic        aluValid;
    logic        aluReady;
    logic [5:0]  aluAddr;
    logic [31:0] aluData;
    logic        macValid;
    logic        macReady;
    logic [5:0]  macAddr;
    logic [31:0] macData;
    logic        wbHold;
`ifdef WB_HAZARD_EN
    logic [5:0]  rdAddrA;
    logic [5:0]  rdAddrB;
    logic [5:0]  rdAddrC;
    logic        hazardA;
    logic        hazardB;
    logic        hazardC;
`endif
    logic        writeEnable;
    logic [5:0]  wrAddr;
    logic [31:0] wrData;
    logic [2:0]  fifoCount;
    logic        idle;

    int checks;
    int errors;

    logic [31:0] rf [64];
    logic [37:0] wlog [$];

    regfile_writeback #(
        .NUM_ADDR_BITS(6),
        .REG_WIDTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .aluValid(aluValid),
        .aluReady(aluReady),
        .aluAddr(aluAddr),
        .aluData(aluData),
        .macValid(macValid),
        .macReady(macReady),
        .macAddr(macAddr),
        .macData(macData),
        .wbHold(wbHold),
`ifdef WB_HAZARD_EN
        .rdAddrA(rdAddrA),
        .rdAddrB(rdAddrB),
        .rdAddrC(rdAddrC),
        .hazardA(hazardA),
        .hazardB(hazardB),
        .hazardC(hazardC),
`endif
        .writeEnable(writeEnable),
        .wrAddr(wrAddr),
        .wrData(wrData),
        .fifoCount(fifoCount),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: commits whatever the write port presents at the edge
    always @(posedge clk) begin
        if (writeEnable) begin
            rf[wrAddr] <= wrData;
            wlog.push_back({wrAddr, wrData});
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input int k, input logic [5:0] a, input logic [31:0] d);
        logic [37:0] entry;
        entry = (k < wlog.size()) ? wlog[k] : {38{1'b1}};
        check_eq(tag, 64'(entry), 64'({a, d}));
    endtask

    initial begin
        int alu_k;
        int mac_k;
        logic exp_alu;

        checks   = 0;
        errors   = 0;
        resetN   = 1'b0;
        aluValid = 1'b0;
        aluAddr  = 6'h00;
        aluData  = 32'h0;
        macValid = 1'b0;
        macAddr  = 6'h00;
        macData  = 32'h0;
        wbHold   = 1'b0;
`ifdef WB_HAZARD_EN
        rdAddrA  = 6'h00;
        rdAddrB  = 6'h00;
        rdAddrC  = 6'h00;
`endif

        // Reset state
        #3;
        check_eq("rst_we", 64'(writeEnable), 64'd0);
        check_eq("rst_addr", 64'(wrAddr), 64'd0);
        check_eq("rst_data", 64'(wrData), 64'd0);
        check_eq("rst_count", 64'(fifoCount), 64'd0);
        check_eq("rst_idle", 64'(idle), 64'd1);
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // Single ALU beat into an idle block
        aluValid = 1'b1;
        aluAddr  = 6'h01;
        aluData  = 32'h14578BB0;
        #1;
        check_eq("t1_alu_ready", 64'(aluReady), 64'd1);
        check_eq("t1_mac_ready", 64'(macReady), 64'd0);
        tick();
        aluValid = 1'b0;
        check_eq("t1_count", 64'(fifoCount), 64'd1);
        check_eq("t1_we_early", 64'(writeEnable), 64'd0);
        tick();
        check_eq("t1_we", 64'(writeEnable), 64'd1);
        check_eq("t1_addr", 64'(wrAddr), 64'h01);
        check_eq("t1_data", 64'(wrData), 64'h14578BB0);
        check_eq("t1_idle_busy", 64'(idle), 64'd0);
        tick();
        check_eq("t1_we_off", 64'(writeEnable), 64'd0);
        check_eq("t1_idle", 64'(idle), 64'd1);
        check_eq("t1_rf", 64'(rf[1]), 64'h14578BB0);

        // Single MAC beat so that the ALU is next in line for a contest
        macValid = 1'b1;
        macAddr  = 6'h04;
        macData  = 32'h0000ABCD;
        #1;
        check_eq("mac_ready", 64'(macReady), 64'd1);
        tick();
        macValid = 1'b0;
        tick();
        tick();
        check_eq("mac_rf", 64'(rf[4]), 64'h0000ABCD);

        // Both producers valid for four cycles: grants alternate ALU, MAC, ...
        wlog.delete();
        alu_k    = 0;
        mac_k    = 0;
        aluAddr  = 6'h02;
        macAddr  = 6'h03;
        aluValid = 1'b1;
        macValid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            aluData = 32'hFFFFFFFF - 32'(alu_k);
            macData = 32'h88888888 + 32'(mac_k);
            exp_alu = ((c % 2) == 0);
            #1;
            check_eq("t2_alu_ready", 64'(aluReady), 64'(exp_alu));
            check_eq("t2_mac_ready", 64'(macReady), 64'(!exp_alu));
            tick();
            check_eq("t2_we_stream", 64'(writeEnable), 64'(c >= 1));
            if (exp_alu) alu_k++;
            else mac_k++;
        end
        aluValid = 1'b0;
        macValid = 1'b0;
        tick();
        check_eq("t2_we_last", 64'(writeEnable), 64'd1);
        tick();
        check_eq("t2_we_done", 64'(writeEnable), 64'd0);
        check_eq("t2_nwrites", 64'(wlog.size()), 64'd4);
        expect_write("t2_w0", 0, 6'h02, 32'hFFFFFFFF);
        expect_write("t2_w1", 1, 6'h03, 32'h88888888);
        expect_write("t2_w2", 2, 6'h02, 32'hFFFFFFFE);
        expect_write("t2_w3", 3, 6'h03, 32'h88888889);

        // Hold the write port while pushing five ALU beats
        wlog.delete();
        wbHold   = 1'b1;
        aluValid = 1'b1;
        aluAddr  = 6'h05;
        for (int k = 0; k < 4; k++) begin
            aluData = 32'hA5A50000 + 32'(k);
            #1;
            check_eq("t3_ready", 64'(aluReady), 64'd1);
            tick();
            check_eq("t3_count", 64'(fifoCount), 64'(k + 1));
            check_eq("t3_we_held", 64'(writeEnable), 64'd0);
        end
        aluData = 32'hA5A50004;
        #1;
        check_eq("t3_full_ready", 64'(aluReady), 64'd0);
        tick();
        check_eq("t3_full_ready2", 64'(aluReady), 64'd0);
        check_eq("t3_full_count", 64'(fifoCount), 64'd4);
        wbHold = 1'b0;
        #1;
        check_eq("t3_full_pop_ready", 64'(aluReady), 64'd0);
        tick();
        check_eq("t3_we_d0", 64'(writeEnable), 64'd1);
        check_eq("t3_count_d0", 64'(fifoCount), 64'd3);
        check_eq("t3_ready_d0", 64'(aluReady), 64'd1);
        tick();
        aluValid = 1'b0;
        check_eq("t3_we_d1", 64'(writeEnable), 64'd1);
        check_eq("t3_count_d1", 64'(fifoCount), 64'd3);
        for (int k = 2; k < 5; k++) begin
            tick();
            check_eq("t3_we_drain", 64'(writeEnable), 64'd1);
            check_eq("t3_count_drain", 64'(fifoCount), 64'(4 - k));
        end
        tick();
        check_eq("t3_we_off", 64'(writeEnable), 64'd0);
        check_eq("t3_idle", 64'(idle), 64'd1);
        check_eq("t3_nwrites", 64'(wlog.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            expect_write("t3_w", k, 6'h05, 32'hA5A50000 + 32'(k));
        end

        // Same address written twice back to back
        wlog.delete();
        aluValid = 1'b1;
        aluAddr  = 6'h3F;
        aluData  = 32'h00000001;
        #1;
        check_eq("t4_ready0", 64'(aluReady), 64'd1);
        tick();
        aluData = 32'hDDDDDDDD;
        #1;
        check_eq("t4_ready1", 64'(aluReady), 64'd1);
        tick();
        aluValid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t4_nwrites", 64'(wlog.size()), 64'd2);
        expect_write("t4_w0", 0, 6'h3F, 32'h00000001);
        expect_write("t4_w1", 1, 6'h3F, 32'hDDDDDDDD);
        check_eq("t4_rf", 64'(rf[63]), 64'hDDDDDDDD);

        // Reset asserted mid-operation with three queued beats
        wlog.delete();
        wbHold   = 1'b1;
        aluValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            aluAddr = 6'h10 + 6'(k);
            aluData = 32'hBAD00000 + 32'(k);
            tick();
        end
        aluValid = 1'b0;
        check_eq("t5_count", 64'(fifoCount), 64'd3);
        wbHold = 1'b0;
        tick();
        check_eq("t5_we_pre", 64'(writeEnable), 64'd1);
        check_eq("t5_count_pre", 64'(fifoCount), 64'd2);
        resetN = 1'b0;
        #1;
        check_eq("t5_we_rst", 64'(writeEnable), 64'd0);
        check_eq("t5_count_rst", 64'(fifoCount), 64'd0);
        check_eq("t5_idle_rst", 64'(idle), 64'd1);
        check_eq("t5_addr_rst", 64'(wrAddr), 64'd0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        tick();
        check_eq("t5_no_writes", 64'(wlog.size()), 64'd0);
        aluValid = 1'b1;
        aluAddr  = 6'h20;
        aluData  = 32'h11111111;
        macValid = 1'b1;
        macAddr  = 6'h21;
        macData  = 32'h22222222;
        #1;
        check_eq("t5_alu_wins", 64'(aluReady), 64'd1);
        check_eq("t5_mac_loses", 64'(macReady), 64'd0);
        tick();
        aluValid = 1'b0;
        #1;
        check_eq("t5_mac_next", 64'(macReady), 64'd1);
        tick();
        macValid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t5_nwrites", 64'(wlog.size()), 64'd2);
        expect_write("t5_w0", 0, 6'h20, 32'h11111111);
        expect_write("t5_w1", 1, 6'h21, 32'h22222222);

`ifdef WB_HAZARD_EN
        // Hazard flags for a queued write to register 0x02
        wbHold   = 1'b1;
        aluValid = 1'b1;
        aluAddr  = 6'h02;
        aluData  = 32'h12345678;
        tick();
        aluValid = 1'b0;
        rdAddrA  = 6'h3F;
        rdAddrB  = 6'h02;
        rdAddrC  = 6'h00;
        #1;
        check_eq("hz_b_queued", 64'(hazardB), 64'd1);
        check_eq("hz_a_clear", 64'(hazardA), 64'd0);
        check_eq("hz_c_clear", 64'(hazardC), 64'd0);
        tick();
        check_eq("hz_b_held", 64'(hazardB), 64'd1);
        wbHold = 1'b0;
        tick();
        check_eq("hz_we", 64'(writeEnable), 64'd1);
        check_eq("hz_b_on_port", 64'(hazardB), 64'd1);
        tick();
        check_eq("hz_b_retired", 64'(hazardB), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
